// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select and IF/ID pipeline register.
// Fetch is a combinational read of imem_addr; the fetched word is registered into IF/ID.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
  parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        if_flush,
  input  logic [2:0]  pcsrc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  input  logic        irq,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        ifid_irq
);

  localparam logic [2:0] SRC_BR    = 3'b001;
  localparam logic [2:0] SRC_J     = 3'b010;
  localparam logic [2:0] SRC_JR    = 3'b011;
  localparam logic [2:0] SRC_ILLOP = 3'b100;
  localparam logic [2:0] SRC_XADR  = 3'b101;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
    logic        irq;
  } ifid_t;

  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  logic [31:0] pc_plus4;
  logic [31:0] redir_tgt;
  logic        redirect;
  logic        irq_take;

  assign pc_plus4 = pc_q + 32'd4;

  // Targets keep the current supervisor bit except the kernel entries;
  // jr can drop supervisor mode but never raise it.
  always_comb begin
    redirect  = 1'b0;
    redir_tgt = pc_plus4;
    unique case (pcsrc)
      SRC_BR: begin
        redirect  = branch_taken;
        redir_tgt = {pc_q[31], branch_target[30:0]};
      end
      SRC_J: begin
        redirect  = 1'b1;
        redir_tgt = {pc_q[31], ifid_q.pc_plus4[30:28], jump_index, 2'b00};
      end
      SRC_JR: begin
        redirect  = 1'b1;
        redir_tgt = {jr_target[31] & pc_q[31], jr_target[30:0]};
      end
      SRC_ILLOP: begin
        redirect  = 1'b1;
        redir_tgt = ILLOP_PC;
      end
      SRC_XADR: begin
        redirect  = 1'b1;
        redir_tgt = XADR_PC;
      end
      default: begin
        redirect  = 1'b0;
        redir_tgt = pc_plus4;
      end
    endcase
  end

  // Interrupts are only taken in user mode and lose to redirects and stalls.
  assign irq_take = pc_write & ~redirect & irq & ~pc_q[31];

  always_comb begin
    pc_d = pc_q;
    if (!pc_write)     pc_d = pc_q;
    else if (redirect) pc_d = redir_tgt;
    else if (irq_take) pc_d = XADR_PC;
    else               pc_d = pc_plus4;
  end

  // Bubble on flush or taken redirect (no delay slot); an accepted irq leaves a
  // marked bubble whose pc_plus4 lets ID recover the interrupted PC as EPC.
  always_comb begin
    ifid_d = ifid_q;
    if (if_flush || (redirect && pc_write)) begin
      ifid_d.instr    = 32'd0;
      ifid_d.pc_plus4 = pc_plus4;
      ifid_d.valid    = 1'b0;
      ifid_d.irq      = 1'b0;
    end else if (!pc_write) begin
      ifid_d = ifid_q;
    end else if (irq_take) begin
      ifid_d.instr    = 32'd0;
      ifid_d.pc_plus4 = pc_plus4;
      ifid_d.valid    = 1'b0;
      ifid_d.irq      = 1'b1;
    end else begin
      ifid_d.instr    = imem_rdata;
      ifid_d.pc_plus4 = pc_plus4;
      ifid_d.valid    = 1'b1;
      ifid_d.irq      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q   <= RESET_PC;
      ifid_q <= '0;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
    end
  end

  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign ifid_instr    = ifid_q.instr;
  assign ifid_pc_plus4 = ifid_q.pc_plus4;
  assign ifid_valid    = ifid_q.valid;
  assign ifid_irq      = ifid_q.irq;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: hand-computed PC / IF/ID values after each edge.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write;
  logic        if_flush;
  logic [2:0]  pcsrc;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic        irq;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        ifid_irq;

  int n_chk = 0;
  int n_err = 0;

  if_stage dut (
    .clk(clk), .reset(reset), .pc_write(pc_write), .if_flush(if_flush),
    .pcsrc(pcsrc), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump_index(jump_index), .jr_target(jr_target), .irq(irq),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
    .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid(ifid_valid), .ifid_irq(ifid_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Return inputs to a plain sequential-fetch cycle.
  task automatic idle;
    reset = 1'b1; pc_write = 1'b1; if_flush = 1'b0; pcsrc = 3'b000;
    branch_taken = 1'b0; irq = 1'b0;
  endtask

  task automatic do_jr(input logic [31:0] t);
    idle; pcsrc = 3'b011; jr_target = t; tick; idle;
  endtask

  task automatic do_br(input logic [31:0] t);
    idle; pcsrc = 3'b001; branch_taken = 1'b1; branch_target = t; tick; idle;
  endtask

  initial begin
    idle; reset = 1'b0; branch_target = '0; jump_index = '0; jr_target = '0;
    imem_rdata = 32'hdead_beef; irq = 1'b1; pcsrc = 3'b011;
    tick; tick;
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_addr", imem_addr, 32'h8000_0000);
    chk("rst_instr", ifid_instr, 0);
    chk("rst_pp4", ifid_pc_plus4, 0);
    chk("rst_valid", {31'd0, ifid_valid}, 0);
    chk("rst_irq", {31'd0, ifid_irq}, 0);

    // free-running fetch
    idle; imem_rdata = 32'h11; tick;
    chk("seq1_pc", pc, 32'h8000_0004);
    chk("seq1_instr", ifid_instr, 32'h11);
    chk("seq1_pp4", ifid_pc_plus4, 32'h8000_0004);
    chk("seq1_valid", {31'd0, ifid_valid}, 1);
    imem_rdata = 32'h22; tick;
    chk("seq2_pc", pc, 32'h8000_0008);
    chk("seq2_instr", ifid_instr, 32'h22);
    chk("seq2_pp4", ifid_pc_plus4, 32'h8000_0008);
    imem_rdata = 32'h33; tick;
    chk("seq3_pc", pc, 32'h8000_000C);
    chk("seq3_instr", ifid_instr, 32'h33);

    // jr out of supervisor mode to reach 00400010
    do_jr(32'h0040_0010);
    chk("jr_pc", pc, 32'h0040_0010);
    chk("jr_valid", {31'd0, ifid_valid}, 0);
    chk("jr_pp4", ifid_pc_plus4, 32'h8000_0010);

    // combined stall: pc holds, IF/ID bubble, then refetch same address
    pc_write = 1'b0; if_flush = 1'b1; imem_rdata = 32'h44; tick;
    chk("stall_pc", pc, 32'h0040_0010);
    chk("stall_instr", ifid_instr, 0);
    chk("stall_valid", {31'd0, ifid_valid}, 0);
    idle; tick;
    chk("refetch_pc", pc, 32'h0040_0014);
    chk("refetch_instr", ifid_instr, 32'h44);
    chk("refetch_pp4", ifid_pc_plus4, 32'h0040_0014);
    chk("refetch_valid", {31'd0, ifid_valid}, 1);

    // taken branch keeps user mode
    do_br(32'h0040_0020);
    chk("br0_pc", pc, 32'h0040_0020);
    do_br(32'h0040_0100);
    chk("brt_pc", pc, 32'h0040_0100);
    chk("brt_valid", {31'd0, ifid_valid}, 0);
    chk("brt_pp4", ifid_pc_plus4, 32'h0040_0024);
    do_br(32'h0040_0020);
    pcsrc = 3'b001; branch_taken = 1'b0; branch_target = 32'h0040_0100;
    imem_rdata = 32'h55; tick; idle;
    chk("brn_pc", pc, 32'h0040_0024);
    chk("brn_instr", ifid_instr, 32'h55);
    chk("brn_valid", {31'd0, ifid_valid}, 1);

    // unused pcsrc encoding behaves as sequential
    pcsrc = 3'b111; imem_rdata = 32'h5a; tick; idle;
    chk("src7_pc", pc, 32'h0040_0028);
    chk("src7_instr", ifid_instr, 32'h5a);

    // j uses ifid_pc_plus4[30:28]
    do_br(32'h0040_0004);
    imem_rdata = 32'h66; tick;
    chk("jpre_pp4", ifid_pc_plus4, 32'h0040_0008);
    pcsrc = 3'b010; jump_index = 26'h010_0040; tick; idle;
    chk("j_pc", pc, 32'h0040_0100);
    chk("j_valid", {31'd0, ifid_valid}, 0);

    // jr cannot enter supervisor mode, but keeps it
    do_jr(32'h8000_1000);
    chk("jr_user_pc", pc, 32'h0000_1000);
    pcsrc = 3'b100; tick; idle;
    chk("illop_pc", pc, 32'h8000_0004);
    do_jr(32'h8000_1000);
    chk("jr_sup_pc", pc, 32'h8000_1000);
    pcsrc = 3'b101; tick; idle;
    chk("xadr_pc", pc, 32'h8000_0008);

    // interrupt accept in user mode
    do_jr(32'h0040_0030);
    irq = 1'b1; imem_rdata = 32'h70; tick;
    chk("irq_pc", pc, 32'h8000_0008);
    chk("irq_mark", {31'd0, ifid_irq}, 1);
    chk("irq_valid", {31'd0, ifid_valid}, 0);
    chk("irq_pp4", ifid_pc_plus4, 32'h0040_0034);
    imem_rdata = 32'h77; tick;
    chk("irqsup_pc", pc, 32'h8000_000C);
    chk("irqsup_mark", {31'd0, ifid_irq}, 0);
    chk("irqsup_instr", ifid_instr, 32'h77);

    // redirect ignored while pc_write=0
    idle; pc_write = 1'b0; pcsrc = 3'b010; jump_index = 26'h3ff_ffff;
    imem_rdata = 32'h88; tick;
    chk("hold_pc", pc, 32'h8000_000C);
    chk("hold_instr", ifid_instr, 32'h77);
    chk("hold_pp4", ifid_pc_plus4, 32'h8000_000C);
    chk("hold_valid", {31'd0, ifid_valid}, 1);

    // reset during stall
    reset = 1'b0; tick;
    chk("rst2_pc", pc, 32'h8000_0000);
    chk("rst2_instr", ifid_instr, 0);
    chk("rst2_pp4", ifid_pc_plus4, 0);
    chk("rst2_valid", {31'd0, ifid_valid}, 0);
    chk("rst2_irq", {31'd0, ifid_irq}, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
